rl_force_output_collector: RTL and testbench
============================================

Name: rl_force_output_collector

Overview:
- Receiving end of the RL_LJ_Top force-output interface.
- Captures the reference-particle and neighbor-particle force streams (ID plus X/Y/Z IEEE-754 single-precision forces) into one in-order FIFO.
- Drains the FIFO to a downstream force-writeback/host consumer through a valid/ready handshake.
- Tracks the end of a home-cell run using the top-level done signal, and raises its own done once every captured result has been drained.

Parameters:
- DATA_WIDTH, 32, force word width (IEEE-754 single)
- PARTICLE_ID_WIDTH, 20, particle ID width (CELL_ID_WIDTH*3+CELL_ADDR_WIDTH)
- FIFO_DEPTH, 16, entries in the result FIFO
- FIFO_ADDR_WIDTH, 4, log2(FIFO_DEPTH)
- CNT_WIDTH, 16, width of the accepted-result counters

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset (resets when 0)
- start  input  1  one-cycle pulse that begins a collection run
- top_done  input  1  done from RL_LJ_Top; held high until its next start
- ref_particle_id  input  PARTICLE_ID_WIDTH  reference particle ID
- ref_force_x/y/z  input  DATA_WIDTH each  reference force components
- ref_valid  input  1  reference result valid (no backpressure)
- nb_particle_id  input  PARTICLE_ID_WIDTH  neighbor particle ID
- nb_force_x/y/z  input  DATA_WIDTH each  neighbor force components
- nb_valid  input  1  neighbor result valid (no backpressure)
- out_valid  output  1  FIFO head entry available
- out_ready  input  1  consumer accepts the head entry
- out_particle_id  output  PARTICLE_ID_WIDTH  head entry ID
- out_force_x/y/z  output  DATA_WIDTH each  head entry forces
- out_is_neighbor  output  1  head entry came from the neighbor stream
- fifo_count  output  FIFO_ADDR_WIDTH+1  current occupancy
- ref_count, nb_count  output  CNT_WIDTH each  results accepted this run
- overflow  output  1  sticky: a valid result was dropped
- collect_done  output  1  run complete and FIFO drained

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; FIFO pointers and count go to 0.
  - Outputs reset to: out_valid=0, fifo_count=0, ref_count=0, nb_count=0, overflow=0, collect_done=0.
  - Data outputs reset to 0. Contents of the FIFO storage are don't-care.
  - Reset mid-run discards all entries; nothing is replayed.
- FSM states: IDLE, COLLECT, DRAIN, DONE.
  - IDLE→COLLECT on start.
  - COLLECT→DRAIN when top_done=1 and `armed`=1.
  - DRAIN→DONE when fifo_count=0 and ref_valid=0 and nb_valid=0 in the same cycle.
  - DONE→COLLECT on start.
  - start in COLLECT or DRAIN is ignored.
- The `armed` flag handles a stale top_done from the previous run:
  - `armed` is cleared on start.
  - `armed` is set the first cycle top_done=0 is seen in COLLECT.
  - top_done is ignored while `armed`=0.
- start (accepted) clears ref_count, nb_count, overflow and collect_done on the next edge. The FIFO is not flushed.
- Capture:
  - Inputs are accepted only in COLLECT or DRAIN. Valids seen in IDLE or DONE are dropped silently: no count, no overflow.
  - Entry = {is_neighbor, id, fx, fy, fz}.
  - Free space is DEPTH − fifo_count, evaluated before this cycle's pop (no pop bypass).
  - Single valid: written if free ≥ 1; otherwise dropped and overflow set.
  - Both valid in one cycle: ref is written first, then neighbor (two writes in one cycle). If free = 1, ref is written, neighbor is dropped and overflow is set. If free = 0, both are dropped and overflow is set.
  - ref_count / nb_count increment once per written entry and wrap modulo 2^CNT_WIDTH.
- Drain:
  - Show-ahead FIFO: out_* present the head entry; out_valid = (fifo_count≠0).
  - A pop occurs when out_valid & out_ready.
  - Write-to-out_valid latency is 1 cycle.
  - Head data stays stable while out_valid=1 and out_ready=0.
  - Push and pop in the same cycle are both performed. fifo_count is updated by (+writes − pop), range 0..DEPTH.
  - Pointers wrap modulo FIFO_DEPTH.
- collect_done is asserted the cycle after entry to DONE (registered) and held until the next accepted start or reset.

Test Plan:
- Basic drain:
  - Stimulus: reset, start; 3 ref results (IDs 1,2,3; fx=32'h3F800000), out_ready=1; then top_done=1.
  - Required: 3 outputs in order with out_is_neighbor=0; ref_count=3; collect_done=1 about 2 cycles after the FIFO empties.
- Simultaneous streams:
  - Stimulus: ref_valid and nb_valid together for 4 cycles (ref IDs 10..13, nb IDs 20..23); out_ready=0, then 1.
  - Required: output order 10,20,11,21,12,22,13,23; fifo_count peaks at 8; ref_count=4, nb_count=4; overflow=0.
- Overflow:
  - Stimulus: out_ready=0; 15 ref results, then one cycle with both valid.
  - Required: ref is written (fifo_count=16); neighbor is dropped; overflow=1 and sticky; nb_count=0.
  - Then a second start clears overflow.
- Backpressure:
  - Stimulus: toggle out_ready every cycle while pushing 1 result/cycle.
  - Required: no loss, no duplication; head stable while out_ready=0.
- Stale done:
  - Stimulus: top_done held high across start, low for 2 cycles, then high again.
  - Required: state stays in COLLECT until top_done rises after going low; collect_done is not asserted early.
- Reset mid-run:
  - Stimulus: assert rst=0 with 5 entries queued.
  - Required: outputs immediately 0 (out_valid=0, fifo_count=0); after release the state is IDLE and valids are ignored until start.

Source files
------------

// File: rtl/rl_force_output_collector_if.sv
// rtl/rl_force_output_collector_if.sv - force-output stream toward the writeback consumer
interface rl_force_output_collector_if #(
    parameter int DATA_WIDTH        = 32,
    parameter int PARTICLE_ID_WIDTH = 20
) ();
    logic                         out_valid;
    logic                         out_ready;
    logic [PARTICLE_ID_WIDTH-1:0] out_particle_id;
    logic [DATA_WIDTH-1:0]        out_force_x;
    logic [DATA_WIDTH-1:0]        out_force_y;
    logic [DATA_WIDTH-1:0]        out_force_z;
    logic                         out_is_neighbor;

    modport master (
        output out_valid, out_particle_id, out_force_x, out_force_y, out_force_z, out_is_neighbor,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_particle_id, out_force_x, out_force_y, out_force_z, out_is_neighbor,
        output out_ready
    );
endinterface

// File: rtl/rl_force_output_collector.sv
// rtl/rl_force_output_collector.sv - collects ref/neighbor force results into an in-order FIFO
module rl_force_output_collector #(
    parameter int DATA_WIDTH        = 32,
    parameter int PARTICLE_ID_WIDTH = 20,
    parameter int FIFO_DEPTH        = 16,
    parameter int FIFO_ADDR_WIDTH   = 4,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         top_done,
    input  logic [PARTICLE_ID_WIDTH-1:0] ref_particle_id,
    input  logic [DATA_WIDTH-1:0]        ref_force_x,
    input  logic [DATA_WIDTH-1:0]        ref_force_y,
    input  logic [DATA_WIDTH-1:0]        ref_force_z,
    input  logic                         ref_valid,
    input  logic [PARTICLE_ID_WIDTH-1:0] nb_particle_id,
    input  logic [DATA_WIDTH-1:0]        nb_force_x,
    input  logic [DATA_WIDTH-1:0]        nb_force_y,
    input  logic [DATA_WIDTH-1:0]        nb_force_z,
    input  logic                         nb_valid,
    rl_force_output_collector_if.master  out_if,
    output logic [FIFO_ADDR_WIDTH:0]     fifo_count,
    output logic [CNT_WIDTH-1:0]         ref_count,
    output logic [CNT_WIDTH-1:0]         nb_count,
    output logic                         overflow,
    output logic                         collect_done
);
    localparam int ENTRY_W = 1 + PARTICLE_ID_WIDTH + 3 * DATA_WIDTH;
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;
    localparam logic [FIFO_ADDR_WIDTH:0] DEPTH_C = (FIFO_ADDR_WIDTH + 1)'(FIFO_DEPTH);

    logic [1:0]                 state_q, state_d;
    logic                       armed_q, armed_d;
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_ADDR_WIDTH:0]   count_q, count_d;
    logic [CNT_WIDTH-1:0]       ref_cnt_q, ref_cnt_d, nb_cnt_q, nb_cnt_d;
    logic                       overflow_q, overflow_d;
    logic                       done_q, done_d;

    logic [ENTRY_W-1:0]         mem [FIFO_DEPTH];
    logic [ENTRY_W-1:0]         ref_entry, nb_entry, head;
    logic [FIFO_ADDR_WIDTH-1:0] nb_addr;
    logic active, start_acc, full, one_left, wr_ref, wr_nb, pop, drop;

    assign ref_entry = {1'b0, ref_particle_id, ref_force_x, ref_force_y, ref_force_z};
    assign nb_entry  = {1'b1, nb_particle_id, nb_force_x, nb_force_y, nb_force_z};

    always_comb begin
        active    = (state_q == S_COLLECT) || (state_q == S_DRAIN);
        start_acc = start && ((state_q == S_IDLE) || (state_q == S_DONE));
        // Free space is judged before this cycle's pop; a pop never makes room for a same-cycle write.
        full      = (count_q == DEPTH_C);
        one_left  = (count_q == DEPTH_C - 1'b1);
        wr_ref    = active && ref_valid && !full;
        wr_nb     = active && nb_valid && !full && !(wr_ref && one_left);
        drop      = active && ((ref_valid && !wr_ref) || (nb_valid && !wr_nb));
        pop       = (count_q != '0) && out_if.out_ready;
        nb_addr   = wr_ptr_q + FIFO_ADDR_WIDTH'(wr_ref);

        wr_ptr_d  = wr_ptr_q + FIFO_ADDR_WIDTH'(wr_ref) + FIFO_ADDR_WIDTH'(wr_nb);
        rd_ptr_d  = rd_ptr_q + FIFO_ADDR_WIDTH'(pop);
        count_d   = count_q + (FIFO_ADDR_WIDTH + 1)'(wr_ref) + (FIFO_ADDR_WIDTH + 1)'(wr_nb)
                    - (FIFO_ADDR_WIDTH + 1)'(pop);
        ref_cnt_d  = start_acc ? '0 : ref_cnt_q + CNT_WIDTH'(wr_ref);
        nb_cnt_d   = start_acc ? '0 : nb_cnt_q + CNT_WIDTH'(wr_nb);
        overflow_d = start_acc ? 1'b0 : (overflow_q || drop);
        done_d     = start_acc ? 1'b0 : (done_q || (state_q == S_DONE));

        // armed guards against a top_done still high from the previous run.
        armed_d = armed_q;
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_COLLECT;
                    armed_d = 1'b0;
                end
            end
            S_COLLECT: begin
                if (!top_done) armed_d = 1'b1;
                if (top_done && armed_q) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if ((count_q == '0) && !ref_valid && !nb_valid) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            armed_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ref_cnt_q  <= '0;
            nb_cnt_q   <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ref_cnt_q  <= ref_cnt_d;
            nb_cnt_q   <= nb_cnt_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ref) mem[wr_ptr_q] <= ref_entry;
        if (wr_nb)  mem[nb_addr]  <= nb_entry;
    end

    // Data is forced to zero when empty so reset presents zeros without clearing storage.
    assign head = (count_q != '0) ? mem[rd_ptr_q] : '0;

    assign out_if.out_valid       = (count_q != '0);
    assign out_if.out_is_neighbor = head[ENTRY_W-1];
    assign out_if.out_particle_id = head[ENTRY_W-2 -: PARTICLE_ID_WIDTH];
    assign out_if.out_force_x     = head[3*DATA_WIDTH-1 -: DATA_WIDTH];
    assign out_if.out_force_y     = head[2*DATA_WIDTH-1 -: DATA_WIDTH];
    assign out_if.out_force_z     = head[DATA_WIDTH-1:0];

    assign fifo_count   = count_q;
    assign ref_count    = ref_cnt_q;
    assign nb_count     = nb_cnt_q;
    assign overflow     = overflow_q;
    assign collect_done = done_q;
endmodule

// File: tb/tb_rl_force_output_collector.sv
// tb/tb_rl_force_output_collector.sv - directed self-checking bench for rl_force_output_collector
module tb_rl_force_output_collector;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, top_done = 1'b0;
    logic [19:0] ref_particle_id = '0, nb_particle_id = '0;
    logic [31:0] ref_force_x = '0, ref_force_y = '0, ref_force_z = '0;
    logic [31:0] nb_force_x = '0, nb_force_y = '0, nb_force_z = '0;
    logic        ref_valid = 1'b0, nb_valid = 1'b0;
    logic [4:0]  fifo_count;
    logic [15:0] ref_count, nb_count;
    logic        overflow, collect_done;
    int          tests_run = 0, tests_failed = 0;

    rl_force_output_collector_if #(.DATA_WIDTH(32), .PARTICLE_ID_WIDTH(20)) o_if ();

    rl_force_output_collector dut (
        .clk(clk), .rst(rst), .start(start), .top_done(top_done),
        .ref_particle_id(ref_particle_id), .ref_force_x(ref_force_x),
        .ref_force_y(ref_force_y), .ref_force_z(ref_force_z), .ref_valid(ref_valid),
        .nb_particle_id(nb_particle_id), .nb_force_x(nb_force_x),
        .nb_force_y(nb_force_y), .nb_force_z(nb_force_z), .nb_valid(nb_valid),
        .out_if(o_if), .fifo_count(fifo_count), .ref_count(ref_count),
        .nb_count(nb_count), .overflow(overflow), .collect_done(collect_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_ref(input int id);
        ref_particle_id = 20'(id);
        ref_force_x = 32'h3F800000;
        ref_force_y = 32'h40000000 + 32'(id);
        ref_force_z = 32'(id);
    endtask

    task automatic set_nb(input int id);
        nb_particle_id = 20'(id);
        nb_force_x = 32'hBF800000;
        nb_force_y = 32'hC0000000 + 32'(id);
        nb_force_z = 32'(id);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pop_check(input string tag, input int id, input logic is_nb);
        o_if.out_ready = 1'b1;
        for (int i = 0; i < 50 && !o_if.out_valid; i++) tick();
        check_val({tag, "_valid"}, o_if.out_valid, 1);
        check_val({tag, "_id"}, o_if.out_particle_id, id);
        check_val({tag, "_nb"}, o_if.out_is_neighbor, is_nb);
        check_val({tag, "_fx"}, o_if.out_force_x, is_nb ? 32'hBF800000 : 32'h3F800000);
        check_val({tag, "_fy"}, o_if.out_force_y, (is_nb ? 32'hC0000000 : 32'h40000000) + 32'(id));
        check_val({tag, "_fz"}, o_if.out_force_z, id);
        tick();
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 20 && !collect_done; i++) tick();
        check_val(tag, collect_done, 1);
    endtask

    initial begin
        int pidx;
        bit hold;
        logic [19:0] held;
        o_if.out_ready = 1'b0;

        // Reset state
        tick(); tick();
        check_val("rst_valid", o_if.out_valid, 0);
        check_val("rst_count", fifo_count, 0);
        check_val("rst_refcnt", ref_count, 0);
        check_val("rst_nbcnt", nb_count, 0);
        check_val("rst_ovf", overflow, 0);
        check_val("rst_done", collect_done, 0);
        check_val("rst_id", o_if.out_particle_id, 0);
        rst = 1'b1;

        // Basic drain
        pulse_start();
        for (int i = 1; i <= 3; i++) begin
            ref_valid = 1'b1; set_ref(i); tick();
        end
        ref_valid = 1'b0;
        check_val("basic_count", fifo_count, 3);
        check_val("basic_refcnt", ref_count, 3);
        top_done = 1'b1;
        for (int i = 1; i <= 3; i++) pop_check("basic_pop", i, 1'b0);
        check_val("basic_done_e0", collect_done, 0);
        tick();
        check_val("basic_done_e1", collect_done, 0);
        tick();
        check_val("basic_done_e2", collect_done, 1);

        // Simultaneous streams
        o_if.out_ready = 1'b0;
        top_done = 1'b0;
        pulse_start();
        check_val("sim_done_clr", collect_done, 0);
        check_val("sim_refcnt_clr", ref_count, 0);
        for (int i = 0; i < 4; i++) begin
            ref_valid = 1'b1; nb_valid = 1'b1; set_ref(10 + i); set_nb(20 + i); tick();
        end
        ref_valid = 1'b0; nb_valid = 1'b0;
        check_val("sim_count", fifo_count, 8);
        check_val("sim_refcnt", ref_count, 4);
        check_val("sim_nbcnt", nb_count, 4);
        check_val("sim_ovf", overflow, 0);
        top_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pop_check("sim_ref", 10 + i, 1'b0);
            pop_check("sim_nb", 20 + i, 1'b1);
        end
        wait_done("sim_done");

        // Overflow
        o_if.out_ready = 1'b0;
        top_done = 1'b0;
        pulse_start();
        for (int i = 0; i < 15; i++) begin
            ref_valid = 1'b1; set_ref(100 + i); tick();
        end
        nb_valid = 1'b1; set_ref(115); set_nb(200); tick();
        nb_valid = 1'b0;
        check_val("ovf_count", fifo_count, 16);
        check_val("ovf_refcnt", ref_count, 16);
        check_val("ovf_nbcnt", nb_count, 0);
        check_val("ovf_flag", overflow, 1);
        set_ref(116); tick();
        ref_valid = 1'b0;
        check_val("full_count", fifo_count, 16);
        check_val("full_refcnt", ref_count, 16);
        pulse_start();
        check_val("collect_start_ign_cnt", ref_count, 16);
        check_val("collect_start_ign_ovf", overflow, 1);
        top_done = 1'b1;
        for (int i = 0; i < 16; i++) pop_check("ovf_pop", 100 + i, 1'b0);
        wait_done("ovf_done");
        check_val("ovf_sticky", overflow, 1);

        // Stale done: top_done still high across this start
        pulse_start();
        check_val("restart_ovf_clr", overflow, 0);
        check_val("restart_refcnt", ref_count, 0);
        o_if.out_ready = 1'b1;
        ref_valid = 1'b1; set_ref(400); tick();
        ref_valid = 1'b0;
        tick(); tick(); tick();
        check_val("stale_no_done", collect_done, 0);
        check_val("stale_refcnt", ref_count, 1);
        check_val("stale_empty", fifo_count, 0);
        top_done = 1'b0;
        tick(); tick();
        check_val("stale_low_done", collect_done, 0);
        top_done = 1'b1;
        tick();
        check_val("stale_rise_done", collect_done, 0);
        wait_done("stale_done");

        // Backpressure
        top_done = 1'b0;
        pulse_start();
        pidx = 0; hold = 1'b0; held = '0;
        for (int c = 0; c < 100 && pidx < 12; c++) begin
            if (c < 12) begin
                ref_valid = 1'b1; set_ref(300 + c);
            end else begin
                ref_valid = 1'b0;
            end
            o_if.out_ready = (c % 2) == 1;
            if (hold && o_if.out_valid) check_val("bp_stable", o_if.out_particle_id, held);
            hold = 1'b0;
            if (o_if.out_valid) begin
                if (o_if.out_ready) begin
                    check_val("bp_order", o_if.out_particle_id, 300 + pidx);
                    pidx++;
                end else begin
                    hold = 1'b1;
                    held = o_if.out_particle_id;
                end
            end
            tick();
        end
        ref_valid = 1'b0;
        o_if.out_ready = 1'b0;
        check_val("bp_popped", pidx, 12);
        check_val("bp_refcnt", ref_count, 12);
        check_val("bp_empty", fifo_count, 0);
        check_val("bp_ovf", overflow, 0);

        // Reset mid-run
        for (int i = 0; i < 5; i++) begin
            ref_valid = 1'b1; set_ref(500 + i); tick();
        end
        ref_valid = 1'b0;
        check_val("mid_count", fifo_count, 5);
        #2 rst = 1'b0;
        #1;
        check_val("mid_rst_valid", o_if.out_valid, 0);
        check_val("mid_rst_count", fifo_count, 0);
        check_val("mid_rst_id", o_if.out_particle_id, 0);
        check_val("mid_rst_refcnt", ref_count, 0);
        tick();
        rst = 1'b1;
        ref_valid = 1'b1; set_ref(600);
        tick(); tick(); tick();
        ref_valid = 1'b0;
        check_val("idle_ign_count", fifo_count, 0);
        check_val("idle_ign_refcnt", ref_count, 0);
        check_val("idle_ign_ovf", overflow, 0);
        pulse_start();
        ref_valid = 1'b1; set_ref(601); tick();
        ref_valid = 1'b0;
        check_val("post_rst_count", fifo_count, 1);
        check_val("post_rst_head", o_if.out_particle_id, 601);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
